// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding
// and the parameter legality rules checked at elaboration.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } cmp_state_t;

  function automatic bit width_legal(input int w);
    return (w >= 2);
  endfunction

  function automatic bit early_exit_legal(input int v);
    return (v == 0) || (v == 1);
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit magnitude compare; invert swaps gt/lt so the sign bit of a
// two's-complement operand weighs negatively.
module bit_compare_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic gt,
  output logic eq,
  output logic lt
);

  logic a_over_b;
  logic b_over_a;

  assign a_over_b = a_bit & ~b_bit;
  assign b_over_a = ~a_bit & b_bit;
  assign eq       = ~(a_bit ^ b_bit);
  assign gt       = invert ? b_over_a : a_over_b;
  assign lt       = invert ? a_over_b : b_over_a;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans operands MSB first, one bit per
// cycle, and reports A>B / A==B / A<B with a one-cycle done pulse.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("seq_magnitude_comparator: WIDTH must be >= 2");
  end
  if (!early_exit_legal(EARLY_EXIT)) begin : g_bad_early_exit
    $error("seq_magnitude_comparator: EARLY_EXIT must be 0 or 1");
  end

  cmp_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IDX_W-1:0] idx;
  logic             found, res_g, res_l;

  logic cell_gt, cell_eq, cell_lt;
  logic cap, finish, last, hit;
  logic dec_g, dec_l;

  bit_compare_cell u_cell (
    .a_bit  (a_q[idx]),
    .b_bit  (b_q[idx]),
    .invert (sm_q && (idx == IDX_MSB)),
    .gt     (cell_gt),
    .eq     (cell_eq),
    .lt     (cell_lt)
  );

  // A difference already recorded (fixed-latency mode) outranks the current bit.
  assign last  = (idx == '0);
  assign hit   = !found && !cell_eq;
  assign dec_g = found ? res_g : cell_gt;
  assign dec_l = found ? res_l : cell_lt;

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cap       = 1'b1;
          state_nxt = ST_COMPARE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (last || ((EARLY_EXIT != 0) && !cell_eq)) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      found <= 1'b0;
      res_g <= 1'b0;
      res_l <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        idx   <= IDX_MSB;
        found <= 1'b0;
        res_g <= 1'b0;
        res_l <= 1'b0;
      end else if (state == ST_COMPARE) begin
        if (hit) begin
          found <= 1'b1;
          res_g <= cell_gt;
          res_l <= cell_lt;
        end
        if (!last) idx <= idx - 1'b1;
      end
      if (finish) begin
        g <= dec_g;
        e <= ~dec_g & ~dec_l;
        l <= dec_l;
      end
    end
  end

  // Operand registers carry data only and are not reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      a_q  <= a;
      b_q  <= b;
      sm_q <= signed_mode;
    end
  end

  assign busy = (state == ST_COMPARE);
  assign done = (state == ST_DONE);

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range WIDTH >= 2.
REQ-002 Parameter EARLY_EXIT, default 1: 1 = finish on first differing bit; 0 = fixed latency of WIDTH compare cycles.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request a comparison; sampled only when not busy.
REQ-006 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
REQ-007 Port a  input  WIDTH  operand A; captured with start.
REQ-008 Port b  input  WIDTH  operand B; captured with start.
REQ-009 Port busy  output  1  high while a comparison is in progress.
REQ-010 Port done  output  1  single-cycle pulse: g/e/l carry a new result.
REQ-011 Ports g, e, l  output  1 each  registered result: A>B, A==B, A<B.

Function
REQ-012 States: IDLE, COMPARE, DONE; the one-cycle DONE state drives done=1.
REQ-013 IDLE or DONE with start=1: capture a, b, signed_mode; bit index = WIDTH-1; go to COMPARE.
REQ-014 start=1 in COMPARE is ignored; captured operands and in-progress state are unchanged.
REQ-015 COMPARE examines one bit per cycle, MSB first, and decrements the index by 1 each cycle.
REQ-016 First differing bit decides the result: A bit 1 -> g, A bit 0 -> l.
REQ-017 In signed mode, a difference found at bit WIDTH-1 is inverted: A bit 1 -> l, A bit 0 -> g.
REQ-018 No difference through bit 0 -> e.
REQ-019 EARLY_EXIT=1: leave COMPARE for DONE the cycle after the first difference is found.
REQ-020 EARLY_EXIT=0: remain in COMPARE until bit 0 has been examined; the first difference is still the one that decides.
REQ-021 Timing (start high in cycle k):
  - busy=1 from cycle k+1 through the last COMPARE cycle.
  - done=1 in cycle k+WIDTH+1 (fixed mode, or equal operands).
  - early exit on a difference at bit i: done=1 in cycle k+WIDTH+1-i.
REQ-022 busy=0 whenever done=1.
REQ-023 g/e/l update in the same cycle done rises and hold until the next done.
REQ-024 After the first done, exactly one of g/e/l is 1 (one-hot).
REQ-025 Back-to-back: start accepted in the DONE cycle enters COMPARE next cycle with no idle gap.
REQ-026 The bit index is a $clog2(WIDTH)-bit down-counter; it never wraps below 0.

Reset
REQ-027 rst=1 at a clock edge forces state IDLE and busy=done=g=e=l=0 in the next cycle, regardless of state.
REQ-028 Reset mid-COMPARE abandons the operation: no done pulse, and the previous result is cleared.
REQ-029 rst has priority over start when both are high.

Structure
REQ-030 State encoding constants (IDLE/COMPARE/DONE) live in shared package cmp_pkg, alongside the parameter legality rules.
REQ-031 One sub-module, bit_compare_cell: 1-bit combinational gt/eq/lt with an invert input for the signed MSB.

Verification (WIDTH=8; start high in cycle k)
REQ-032 Unsigned a=0xA5, b=0xA4 -> decided at bit 0; done in k+9 in both EARLY_EXIT modes; g=1, e=l=0.
REQ-033 a=0x80, b=0x7F -> signed: l=1, unsigned: g=1.
  - EARLY_EXIT=1: done in k+2.
  - EARLY_EXIT=0: done in k+9.
REQ-034 a=b=0x3C -> e=1 with done in k+9.
  - start pulsed in k+3 is ignored; operands are unchanged.
  - a new start in the done cycle yields a second done in k+18.
REQ-035 rst in cycle k+3 of a compare -> cycle k+4: busy=done=g=e=l=0, state IDLE; no done follows.
REQ-036 Random 10k operand pairs, both modes and both EARLY_EXIT values, checked against a reference model:
  - g/e/l always one-hot after the first done.
  - latency always matches REQ-021.
